fc_weight_loader: RTL
=====================

# fc_weight_loader

Writer side of the FC weight path. Accepts a serial 8-bit weight stream over a valid/ready handshake, assembles it into the full neuron × tap weight array, and presents that array with a qualifying valid flag. The array feeds `fc_weight_buffer`, which slices it by address. The block sits between the E203 bus-side weight DMA and the FC layer datapath.

## Interface
Parameters:
- `NEURONS`, default 10: output neurons.
- `TAPS`, default 9: weights per neuron.
- `DW`, default 8: weight width in bits.

Ports:
- `i_clk`  in  1  clock; all logic rises on the posedge.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_start`  in  1  one-cycle pulse that begins a load.
- `i_valid`  in  1  stream byte valid.
- `i_data`  in  DW  stream weight byte.
- `o_ready`  out  1  loader accepts a byte this cycle.
- `o_weight`  out  DW × [NEURONS][TAPS]  assembled weight array, wired straight to the buffer's `i_weight`.
- `o_weight_valid`  out  1  array is complete and stable.
- `o_busy`  out  1  a load is in progress.
- `o_checksum`  out  16  running byte sum. Present only with `FC_WLOAD_CHECKSUM_EN`.

## Operation
- FSM states are IDLE, LOAD and DONE.
- IDLE → LOAD on `i_start`. Entry clears the tap counter `t`, neuron counter `n` and `o_weight_valid`. The array is not cleared.
- In LOAD, `o_ready`=1. A transfer occurs when `i_valid && o_ready`.
- Each transfer writes `o_weight[n][t] <= i_data` and advances the counters:
  - if `t==TAPS-1`, then `t<=0` and `n<=n+1`;
  - otherwise `t<=t+1`.
- Byte order is neuron-major, taps ascending. The stream is NEURONS*TAPS bytes (90 at the defaults).
- The transfer at `n==NEURONS-1, t==TAPS-1` moves the FSM to DONE and sets `o_weight_valid`=1.
- DONE holds the array and the valid flag. `i_start` in DONE re-enters LOAD, which drops `o_weight_valid` and restarts at [0][0].
- `i_start` while in LOAD is ignored; counters continue.
- Outputs by state:
  - `o_ready` is 0 in IDLE and DONE.
  - `i_valid` outside LOAD has no effect.
  - `o_busy` is 1 exactly in LOAD.
- Counter widths are `$clog2(TAPS)` and `$clog2(NEURONS)`. The counters never exceed TAPS-1 and NEURONS-1.

## Timing
- Reset values: state=IDLE, `o_ready`=0, `o_busy`=0, `o_weight_valid`=0, every `o_weight` entry=0, counters=0, `o_checksum`=0.
- `i_rst` wins over every other input in the same cycle.
- Reset mid-load returns to IDLE with the array zeroed. A partial array is never flagged valid.
- `o_ready` and `o_busy` rise on the edge that samples `i_start`, so they are high from the following cycle.
- A byte accepted at edge k is visible on `o_weight` after edge k.
- The final byte sets `o_weight_valid` on the same edge. `o_ready` is low the next cycle.
- Minimum load time is 90 cycles after the `i_start` cycle. Bubbles on `i_valid` extend it one cycle each.
- `o_weight` entries change only on accepted transfers.

## Configuration
- `FC_WLOAD_CHECKSUM_EN` defined:
  - 16-bit `o_checksum` is cleared on entry to LOAD.
  - Each accepted byte adds its unsigned value, wrapping mod 2^16.
  - The value is held in DONE.
- Undefined: the port and the accumulator are absent, and all other behaviour is identical.

## Structure
- Package `cnn_fc_pkg` holds:
  - `FC_NEURONS`=10, `FC_TAPS`=9, `FC_DW`=8;
  - the `fc_wload_state_e` enum (IDLE, LOAD, DONE).
- The `fc_weight_buffer` bench imports the same constants.
- One sub-module, `fc_wload_index_ctr`: the nested tap/neuron counter with clear, advance and last-element flag.
- Array storage and the FSM stay in the top module.

## Test plan
- Full load: pulse start, then stream bytes 0..89 with `i_valid` held high. Required: `o_weight[3][4]`=31 and `o_weight[9][8]`=89; `o_weight_valid` rises on the edge of byte 89; `o_ready`=0 afterwards; 91 cycles from start to valid.
- Backpressure bubbles: stream bytes 0..89 with `i_valid` low every third cycle. Required: identical final array, with valid arriving later by the number of bubbles.
- Reset mid-load: assert `i_rst` after 40 bytes, then a fresh start and 90 bytes of 0xFF. Required: after reset all entries=0 and valid=0; after the reload all entries=0xFF and valid=1.
- Start during LOAD: pulse `i_start` at byte 20. Required: counters are not reset, and byte 89 still lands at [9][8].
- Reload from DONE: after the first load, start again. Required: valid drops the next cycle; the old array holds until overwritten; new bytes 100..189 give [0][0]=100.
- With `FC_WLOAD_CHECKSUM_EN`: bytes 0..89 give `o_checksum`=0x0FA5.

Source files
------------

// File: rtl/cnn_fc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_fc_pkg
// Description : Shared FC-layer constants and the weight-loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_fc_pkg;

    localparam int FC_NEURONS = 10;
    localparam int FC_TAPS    = 9;
    localparam int FC_DW      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } fc_wload_state_e;

endpackage
`default_nettype wire

// File: rtl/fc_wload_index_ctr.sv
`default_nettype none
// ============================================================================
// Module      : fc_wload_index_ctr
// Description : Nested tap/neuron index counter; flags the final array element.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_wload_index_ctr #(
    parameter int NEURONS = 10,
    parameter int TAPS    = 9,
    localparam int TW     = (TAPS > 1) ? $clog2(TAPS) : 1,
    localparam int NW     = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_advance,
    output logic [TW-1:0] o_tap,
    output logic [NW-1:0] o_neuron,
    output logic          o_last
);

    localparam logic [TW-1:0] C_TAP_LAST    = TW'(TAPS - 1);
    localparam logic [NW-1:0] C_NEURON_LAST = NW'(NEURONS - 1);

    logic [TW-1:0] r_tap;
    logic [NW-1:0] r_neuron;
    logic          w_tap_wrap;

    assign w_tap_wrap = (r_tap == C_TAP_LAST);

    // Clear has priority so a restart never inherits a half-stepped index.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_tap    <= '0;
            r_neuron <= '0;
        end else if (i_advance) begin
            if (w_tap_wrap) begin
                r_tap    <= '0;
                r_neuron <= r_neuron + NW'(1);
            end else begin
                r_tap    <= r_tap + TW'(1);
            end
        end
    end

    assign o_tap    = r_tap;
    assign o_neuron = r_neuron;
    assign o_last   = w_tap_wrap && (r_neuron == C_NEURON_LAST);

endmodule
`default_nettype wire

// File: rtl/fc_weight_loader.sv
`default_nettype none
// ============================================================================
// Module      : fc_weight_loader
// Description : Assembles a serial weight byte stream into the neuron x tap
//               array. Optional running checksum: FC_WLOAD_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_weight_loader
    import cnn_fc_pkg::*;
#(
    parameter int NEURONS = FC_NEURONS,
    parameter int TAPS    = FC_TAPS,
    parameter int DW      = FC_DW
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic                                   i_start,
    input  logic                                   i_valid,
    input  logic [DW-1:0]                          i_data,
    output logic                                   o_ready,
    output logic [NEURONS-1:0][TAPS-1:0][DW-1:0]   o_weight,
    output logic                                   o_weight_valid,
    output logic                                   o_busy
`ifdef FC_WLOAD_CHECKSUM_EN
    ,
    output logic [15:0]                            o_checksum
`endif
);

    localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int NW = (NEURONS > 1) ? $clog2(NEURONS) : 1;

    fc_wload_state_e                        r_state;
    logic                                   r_ready;
    logic                                   r_busy;
    logic                                   r_weight_valid;
    logic [NEURONS-1:0][TAPS-1:0][DW-1:0]   r_weight;
    logic [TW-1:0]                          w_tap;
    logic [NW-1:0]                          w_neuron;
    logic                                   w_last;
    logic                                   w_enter;
    logic                                   w_accept;
`ifdef FC_WLOAD_CHECKSUM_EN
    logic [15:0]                            r_checksum;
`endif

    // A start pulse only counts from IDLE or DONE; mid-load pulses are ignored.
    assign w_enter  = i_start && (r_state != LOAD);
    assign w_accept = (r_state == LOAD) && i_valid;

    fc_wload_index_ctr #(
        .NEURONS (NEURONS),
        .TAPS    (TAPS)
    ) u_index_ctr (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (w_enter),
        .i_advance (w_accept),
        .o_tap     (w_tap),
        .o_neuron  (w_neuron),
        .o_last    (w_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= IDLE;
            r_ready        <= 1'b0;
            r_busy         <= 1'b0;
            r_weight_valid <= 1'b0;
            r_weight       <= '0;
`ifdef FC_WLOAD_CHECKSUM_EN
            r_checksum     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_state        <= LOAD;
                        r_ready        <= 1'b1;
                        r_busy         <= 1'b1;
                        r_weight_valid <= 1'b0;
`ifdef FC_WLOAD_CHECKSUM_EN
                        r_checksum     <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (i_valid) begin
                        r_weight[w_neuron][w_tap] <= i_data;
`ifdef FC_WLOAD_CHECKSUM_EN
                        r_checksum <= r_checksum + 16'(i_data);
`endif
                        if (w_last) begin
                            r_state        <= DONE;
                            r_ready        <= 1'b0;
                            r_busy         <= 1'b0;
                            r_weight_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready        = r_ready;
    assign o_busy         = r_busy;
    assign o_weight_valid = r_weight_valid;
    assign o_weight       = r_weight;
`ifdef FC_WLOAD_CHECKSUM_EN
    assign o_checksum     = r_checksum;
`endif

endmodule
`default_nettype wire
